// File: rtl/sfu_coef_fetch_if.sv
// Request, result and coefficient-ROM port bundle of the SFU coefficient fetch unit.
// master: the surrounding pipeline / ROM side; slave: the fetch unit itself.
interface sfu_coef_fetch_if #(
  parameter int IDX_W = 13,
  parameter int C0_W  = 29,
  parameter int C1_W  = 25,
  parameter int C2_W  = 17,
  parameter int A_W   = 14
);
  logic                          in_valid;
  logic                          in_ready;
  logic [3:0]                    in_opcode;
  logic [IDX_W-1:0]              in_idx;

  logic                          out_valid;
  logic                          out_ready;
  logic [C0_W-1:0]               out_c0;
  logic [C1_W-1:0]               out_c1;
  logic [C2_W-1:0]               out_c2;
  logic [A_W-1:0]                out_a;
  logic                          out_err;

  logic                          rom_en;
  logic [IDX_W+2:0]              rom_addr;
  logic [C0_W+C1_W+C2_W+A_W-1:0] rom_rdata;

  modport master (
    output in_valid, in_opcode, in_idx, out_ready, rom_rdata,
    input  in_ready, out_valid, out_c0, out_c1, out_c2, out_a, out_err,
           rom_en, rom_addr
  );

  modport slave (
    input  in_valid, in_opcode, in_idx, out_ready, rom_rdata,
    output in_ready, out_valid, out_c0, out_c1, out_c2, out_a, out_err,
           rom_en, rom_addr
  );
endinterface

// File: rtl/sfu_coef_fetch.sv
// Pipelined coefficient fetch for the SFU quadratic interpolator.
// Stage A tracks the request whose ROM read is in flight (two beats for SQRT,
// which combines the SQRT and RSQRT banks); stage B is the output register.
// Optional request/error statistics counters: define SFU_COEF_STATS_EN.
//
// state   | meaning
// A_EMPTY | no request in flight
// A_FULL  | ROM data (or error marker) for the held request is ready
// A_SQRT1 | SQRT first beat returned; bank-2 read being issued
module sfu_coef_fetch #(
  parameter int IDX_W       = 13,
  parameter int C0_W        = 29,
  parameter int C1_W        = 25,
  parameter int C2_W        = 17,
  parameter int A_W         = 14,
  parameter int SQRT_C1_SHR = 4,
  parameter int SQRT_C2_SHR = 9
`ifdef SFU_COEF_STATS_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  sfu_coef_fetch_if.slave    bus
`ifdef SFU_COEF_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   stat_req,
  output logic [CNT_W-1:0]   stat_err
`endif
);

  localparam int RD_W = C0_W + C1_W + C2_W + A_W;
  localparam int AD_W = 3 + IDX_W;

  typedef enum logic [1:0] {A_EMPTY, A_FULL, A_SQRT1} a_state_t;

  a_state_t         a_state;
  logic             a_sqrt;
  logic             a_err;
  logic [IDX_W-1:0] a_idx;
  logic [C0_W-1:0]  sqrt_c0_q;

  logic             b_valid;
  logic [C0_W-1:0]  b_c0;
  logic [C1_W-1:0]  b_c1;
  logic [C2_W-1:0]  b_c2;
  logic [A_W-1:0]   b_a;
  logic             b_err;

  logic             adv;
  logic             accept;
  logic             load;
  logic [2:0]       op_bank;
  logic             op_table;
  logic             op_sqrt;
  logic             op_full_idx;
  logic [IDX_W-1:0] op_idx;
  logic             rom_en_c;
  logic [AD_W-1:0]  rom_addr_c;

  logic [C0_W-1:0]  rd_c0;
  logic [C1_W-1:0]  rd_c1;
  logic [C2_W-1:0]  rd_c2;
  logic [A_W-1:0]   rd_a;
  logic [C1_W-1:0]  sqrt_c1;
  logic [C2_W-1:0]  sqrt_c2;

  assign rd_c0 = bus.rom_rdata[RD_W-1 -: C0_W];
  assign rd_c1 = bus.rom_rdata[C1_W+C2_W+A_W-1 -: C1_W];
  assign rd_c2 = bus.rom_rdata[C2_W+A_W-1 -: C2_W];
  assign rd_a  = bus.rom_rdata[A_W-1:0];

  // SQRT slope terms are scaled-down RSQRT coefficients (arithmetic shift, then truncate).
  assign sqrt_c1 = C1_W'($signed(rd_c0) >>> SQRT_C1_SHR);
  assign sqrt_c2 = C2_W'($signed(rd_c1) >>> SQRT_C2_SHR);

  assign adv          = ~b_valid | bus.out_ready;
  assign bus.in_ready = adv & (a_state != A_SQRT1);
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = adv & (a_state == A_FULL);

  // Opcode to ROM bank decode; only TANH/SIGMOID tables use the full index.
  always_comb begin
    op_bank     = 3'd0;
    op_table    = 1'b1;
    op_sqrt     = 1'b0;
    op_full_idx = 1'b0;
    case (bus.in_opcode)
      4'd0:      op_bank = 3'd0;
      4'd1:      begin op_bank = 3'd1; op_sqrt = 1'b1; end
      4'd2:      op_bank = 3'd2;
      4'd3:      op_bank = 3'd3;
      4'd4:      op_bank = 3'd4;
      4'd5:      op_bank = 3'd5;
      4'd7, 4'd8: begin op_bank = 3'd6; op_full_idx = 1'b1; end
      default:   op_table = 1'b0;
    endcase
  end

  assign op_idx = op_full_idx ? bus.in_idx : {1'b0, bus.in_idx[IDX_W-2:0]};

  // ROM strobe: accepted table request, or SQRT second beat. Held low in reset.
  always_comb begin
    rom_en_c   = 1'b0;
    rom_addr_c = '0;
    if (a_state == A_SQRT1) begin
      rom_en_c   = 1'b1;
      rom_addr_c = {3'd2, a_idx};
    end else if (accept && op_table) begin
      rom_en_c   = 1'b1;
      rom_addr_c = {op_bank, op_idx};
    end
  end

  assign bus.rom_en   = rom_en_c & rst_n;
  assign bus.rom_addr = bus.rom_en ? rom_addr_c : '0;

  // Stage A: in-flight request tracking and SQRT first-beat capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state   <= A_EMPTY;
      a_sqrt    <= 1'b0;
      a_err     <= 1'b0;
      a_idx     <= '0;
      sqrt_c0_q <= '0;
    end else begin
      case (a_state)
        A_SQRT1: begin
          a_state   <= A_FULL;
          sqrt_c0_q <= rd_c0;
        end
        default: begin
          if (accept) begin
            a_state <= op_sqrt ? A_SQRT1 : A_FULL;
            a_sqrt  <= op_sqrt;
            a_err   <= ~op_table;
            a_idx   <= op_idx;
          end else if (adv) begin
            a_state <= A_EMPTY;
          end
        end
      endcase
    end
  end

  // Stage B: output register, loaded from ROM data or the error path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_c0    <= '0;
      b_c1    <= '0;
      b_c2    <= '0;
      b_a     <= '0;
      b_err   <= 1'b0;
    end else if (load) begin
      b_valid <= 1'b1;
      if (a_err) begin
        b_c0  <= '0;
        b_c1  <= '0;
        b_c2  <= '0;
        b_a   <= '0;
        b_err <= 1'b1;
      end else if (a_sqrt) begin
        b_c0  <= sqrt_c0_q;
        b_c1  <= sqrt_c1;
        b_c2  <= sqrt_c2;
        b_a   <= rd_a;
        b_err <= 1'b0;
      end else begin
        b_c0  <= rd_c0;
        b_c1  <= rd_c1;
        b_c2  <= rd_c2;
        b_a   <= rd_a;
        b_err <= 1'b0;
      end
    end else if (bus.out_ready) begin
      b_valid <= 1'b0;
    end
  end

  assign bus.out_valid = b_valid;
  assign bus.out_c0    = b_c0;
  assign bus.out_c1    = b_c1;
  assign bus.out_c2    = b_c2;
  assign bus.out_a     = b_a;
  assign bus.out_err   = b_err;

`ifdef SFU_COEF_STATS_EN
  // Accepted-request and error-opcode counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req <= '0;
      stat_err <= '0;
    end else if (stat_clr) begin
      stat_req <= '0;
      stat_err <= '0;
    end else begin
      if (accept)              stat_req <= stat_req + CNT_W'(1);
      if (accept && !op_table) stat_err <= stat_err + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sfu_coef_fetch.sv
// Self-checking bench for sfu_coef_fetch: directed vector table, hand-written
// multi-cycle sequences and a randomized backpressure run against a reference model.
module tb_sfu_coef_fetch;
  localparam int IDX_W = 13;
  localparam int C0_W  = 29;
  localparam int C1_W  = 25;
  localparam int C2_W  = 17;
  localparam int A_W   = 14;
  localparam int RD_W  = C0_W + C1_W + C2_W + A_W;
  localparam int AD_W  = 3 + IDX_W;
  localparam int N_RND = 200;

  typedef struct packed {
    logic [C0_W-1:0] c0;
    logic [C1_W-1:0] c1;
    logic [C2_W-1:0] c2;
    logic [A_W-1:0]  a;
    logic            err;
  } exp_t;

  typedef struct {
    logic [3:0]       op;
    logic [IDX_W-1:0] idx;
    logic             ren;
    logic [AD_W-1:0]  addr;
    logic             err;
    int               lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RD_W-1:0] rom_q = '0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sfu_coef_fetch_if #(.IDX_W(IDX_W), .C0_W(C0_W), .C1_W(C1_W), .C2_W(C2_W), .A_W(A_W)) bus ();

`ifdef SFU_COEF_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_req;
  logic [31:0] stat_err;
`endif

  sfu_coef_fetch #(
    .IDX_W(IDX_W), .C0_W(C0_W), .C1_W(C1_W), .C2_W(C2_W), .A_W(A_W),
    .SQRT_C1_SHR(4), .SQRT_C2_SHR(9)
`ifdef SFU_COEF_STATS_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef SFU_COEF_STATS_EN
    , .stat_clr(stat_clr), .stat_req(stat_req), .stat_err(stat_err)
`endif
  );

  // Coefficient ROM contents: hashed words plus fixed entries for the SQRT case.
  function automatic logic [RD_W-1:0] rom_word(input logic [AD_W-1:0] addr);
    logic [95:0] h;
    logic [31:0] x;
    logic [RD_W-1:0] w;
    x = {16'h0, addr} + 32'd1;
    h = {x * 32'h9E3779B1, (x ^ 32'h00005A5A) * 32'h85EBCA6B, x * 32'hC2B2AE35};
    w = h[RD_W-1:0];
    if (addr == {3'd1, 13'h0005}) w[RD_W-1 -: C0_W] = 29'h1234567;
    if (addr == {3'd2, 13'h0005}) w = {29'h10000000, 25'h0000200, 17'h0ABCD, 14'h0123};
    return w;
  endfunction

  // Synchronous ROM: data the cycle after rom_en, held otherwise.
  always @(posedge clk) if (bus.rom_en) rom_q <= rom_word(bus.rom_addr);
  assign bus.rom_rdata = rom_q;

  // Reference result for one request, straight from the opcode/bank rules.
  function automatic exp_t model(input logic [3:0] op, input logic [IDX_W-1:0] idx);
    exp_t e;
    logic [2:0] bank;
    logic [IDX_W-1:0] mi;
    logic [RD_W-1:0] w;
    logic [RD_W-1:0] w1;
    longint s;
    logic [63:0] t;
    bit tbl;
    bit sq;
    e = '0;
    bank = 3'd0;
    tbl = 1'b1;
    sq = 1'b0;
    case (op)
      4'd0: bank = 3'd0;
      4'd1: begin bank = 3'd2; sq = 1'b1; end
      4'd2: bank = 3'd2;
      4'd3: bank = 3'd3;
      4'd4: bank = 3'd4;
      4'd5: bank = 3'd5;
      4'd7, 4'd8: bank = 3'd6;
      default: tbl = 1'b0;
    endcase
    mi = (bank == 3'd6) ? idx : IDX_W'(idx % 4096);
    if (!tbl) begin
      e.err = 1'b1;
    end else begin
      w = rom_word({bank, mi});
      e.c0 = w[RD_W-1 -: C0_W];
      e.c1 = w[C1_W+C2_W+A_W-1 -: C1_W];
      e.c2 = w[C2_W+A_W-1 -: C2_W];
      e.a  = w[A_W-1:0];
      if (sq) begin
        w1 = rom_word({3'd1, mi});
        s = longint'($signed(w[RD_W-1 -: C0_W]));
        t = s >>> 4;
        e.c1 = t[C1_W-1:0];
        s = longint'($signed(w[C1_W+C2_W+A_W-1 -: C1_W]));
        t = s >>> 9;
        e.c2 = t[C2_W-1:0];
        e.c0 = w1[RD_W-1 -: C0_W];
      end
    end
    return e;
  endfunction

  function automatic exp_t got();
    return {bus.out_c0, bus.out_c1, bus.out_c2, bus.out_a, bus.out_err};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One cycle: drive inputs after the falling edge, sample 2 ns later.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [IDX_W-1:0] idx, input logic rdy);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_opcode = op;
    bus.in_idx = idx;
    bus.out_ready = rdy;
    #2;
  endtask

  task automatic run_one(input vec_t v, input int k);
    exp_t e;
    int lat;
    e = model(v.op, v.idx);
    cyc(1'b1, v.op, v.idx, 1'b1);
    chk($sformatf("v%0d_in_ready", k), bus.in_ready, 1);
    chk($sformatf("v%0d_rom_en", k), bus.rom_en, v.ren);
    chk($sformatf("v%0d_rom_addr", k), bus.rom_addr, v.addr);
    lat = 0;
    for (int w = 1; w <= 8 && lat == 0; w++) begin
      cyc(1'b0, 4'd0, '0, 1'b1);
      if (bus.out_valid) lat = w;
    end
    chk($sformatf("v%0d_latency", k), lat, v.lat);
    chk($sformatf("v%0d_coefs", k), got(), e);
    chk($sformatf("v%0d_err", k), bus.out_err, v.err);
    cyc(1'b0, 4'd0, '0, 1'b1);
    chk($sformatf("v%0d_drain", k), bus.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    exp_t q[$];
    exp_t e;
    exp_t prev;
    logic prev_stall;
    logic pend;
    logic [3:0] pop;
    logic [IDX_W-1:0] pidx;
    int sent, recv, nerr;
    bit stale;

    vt[0]  = '{4'd7,  13'h1ABC, 1'b1, {3'd6, 13'h1ABC}, 1'b0, 2};
    vt[1]  = '{4'd4,  13'h1ABC, 1'b1, {3'd4, 13'h0ABC}, 1'b0, 2};
    vt[2]  = '{4'd8,  13'h1234, 1'b1, {3'd6, 13'h1234}, 1'b0, 2};
    vt[3]  = '{4'd6,  13'h0042, 1'b0, 16'h0000,          1'b1, 2};
    vt[4]  = '{4'd12, 13'h1FFF, 1'b0, 16'h0000,          1'b1, 2};
    vt[5]  = '{4'd0,  13'h1FFF, 1'b1, {3'd0, 13'h0FFF}, 1'b0, 2};
    vt[6]  = '{4'd5,  13'h1000, 1'b1, {3'd5, 13'h0000}, 1'b0, 2};
    vt[7]  = '{4'd3,  13'h0777, 1'b1, {3'd3, 13'h0777}, 1'b0, 2};
    vt[8]  = '{4'd2,  13'h1555, 1'b1, {3'd2, 13'h0555}, 1'b0, 2};
    vt[9]  = '{4'd1,  13'h1005, 1'b1, {3'd1, 13'h0005}, 1'b0, 3};
    vt[10] = '{4'd15, 13'h0000, 1'b0, 16'h0000,          1'b1, 2};

    // Reset with a request pending on the input.
    bus.in_valid = 1'b1;
    bus.in_opcode = 4'd0;
    bus.in_idx = 13'h0003;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_coefs", got(), '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'd0, '0, 1'b1);
      if (bus.out_valid || bus.rom_en) stale = 1'b1;
    end
    chk("rst_no_stale_output", stale, 0);
    chk("rst_in_ready_after", bus.in_ready, 1);

    // Back-to-back RCP stream, one result per cycle at accept+2.
    for (int k = 0; k < 7; k++) begin
      cyc(k < 4, 4'd0, IDX_W'(k), 1'b1);
      if (k < 4) begin
        chk($sformatf("rcp%0d_in_ready", k), bus.in_ready, 1);
        chk($sformatf("rcp%0d_rom_en", k), bus.rom_en, 1);
        chk($sformatf("rcp%0d_rom_addr", k), bus.rom_addr, {3'd0, 13'(k)});
      end
      chk($sformatf("rcp_cyc%0d_out_valid", k), bus.out_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5)
        chk($sformatf("rcp%0d_coefs", k - 2), got(), model(4'd0, IDX_W'(k - 2)));
    end

    // SQRT two-beat read with fixed expected coefficients.
    cyc(1'b1, 4'd1, 13'h0005, 1'b1);
    chk("sqrt_rom_addr_b1", bus.rom_addr, {3'd1, 13'h0005});
    cyc(1'b1, 4'd0, 13'h0009, 1'b1);
    chk("sqrt_in_ready_beat2", bus.in_ready, 0);
    chk("sqrt_rom_en_b2", bus.rom_en, 1);
    chk("sqrt_rom_addr_b2", bus.rom_addr, {3'd2, 13'h0005});
    cyc(1'b0, 4'd0, '0, 1'b1);
    chk("sqrt_in_ready_back", bus.in_ready, 1);
    chk("sqrt_not_yet_valid", bus.out_valid, 0);
    cyc(1'b0, 4'd0, '0, 1'b1);
    chk("sqrt_out_valid", bus.out_valid, 1);
    chk("sqrt_c0", bus.out_c0, 29'h1234567);
    chk("sqrt_c1", bus.out_c1, 25'h1000000);
    chk("sqrt_c2", bus.out_c2, 17'h00001);
    chk("sqrt_a", bus.out_a, 14'h0123);
    chk("sqrt_err", bus.out_err, 0);
    cyc(1'b0, 4'd0, '0, 1'b1);
    chk("sqrt_drain", bus.out_valid, 0);

    // Vector table: bank map, index masking, error opcodes.
    for (int k = 0; k < 11; k++) run_one(vt[k], k);

    // Asynchronous reset while in the SQRT second beat with a result held.
    cyc(1'b1, 4'd0, 13'h0009, 1'b1);
    cyc(1'b1, 4'd1, 13'h0005, 1'b1);
    chk("mr_sqrt_accepted", bus.in_ready, 1);
    cyc(1'b0, 4'd0, '0, 1'b0);
    chk("mr_pre_out_valid", bus.out_valid, 1);
    chk("mr_pre_rom_en", bus.rom_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_rom_en", bus.rom_en, 0);
    chk("mr_rom_addr", bus.rom_addr, 0);
    chk("mr_in_ready", bus.in_ready, 1);
    chk("mr_coefs", got(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    run_one('{4'd0, 13'h0007, 1'b1, {3'd0, 13'h0007}, 1'b0, 2}, 100);

`ifdef SFU_COEF_STATS_EN
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
`endif

    // Randomized mixed traffic under random backpressure.
    sent = 0;
    recv = 0;
    nerr = 0;
    pend = 1'b0;
    pop = 4'd0;
    pidx = '0;
    prev = '0;
    prev_stall = 1'b0;
    for (int c = 0; c < 6000 && recv < N_RND; c++) begin
      if (!pend && sent < N_RND && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pop = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
        pidx = IDX_W'($urandom);
      end
      cyc(pend, pop, pidx, $urandom_range(0, 2) != 0);
      if (prev_stall) begin
        chk("rnd_stall_valid", bus.out_valid, 1);
        chk("rnd_stall_data", got(), prev);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("rnd_expected_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk($sformatf("rnd_out%0d", recv), got(), e);
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(pop, pidx));
        if (model(pop, pidx).err) nerr++;
        sent++;
        pend = 1'b0;
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev = got();
    end
    chk("rnd_received", recv, N_RND);
    chk("rnd_sent", sent, N_RND);
    chk("rnd_queue_empty", q.size(), 0);
`ifdef SFU_COEF_STATS_EN
    chk("stat_req", stat_req, N_RND);
    chk("stat_err", stat_err, nerr);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
